// File: rtl/btn_debounce_in.sv
// btn_debounce_in: board push-buttons into the 100 MHz domain -- 2-flop sync, debounce FSM, press/release pulses, press counters.
// Long-press detection is compiled in only with `define BTN_LONG_PRESS_EN; otherwise btn_long_o is tied to 0.
module btn_debounce_in #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 8,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic                   clk_100_i,
    input  logic                   rst_n_i,
    input  logic [N_BTN-1:0]       btn_i,
    input  logic                   clr_cnt_i,
    output logic [N_BTN-1:0]       btn_level_o,
    output logic [N_BTN-1:0]       btn_press_o,
    output logic [N_BTN-1:0]       btn_release_o,
    output logic [N_BTN*CNT_W-1:0] press_cnt_o,
    output logic [N_BTN-1:0]       btn_long_o
);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [1:0] STABLE_LO = 2'd0;
    localparam logic [1:0] WAIT_HI   = 2'd1;
    localparam logic [1:0] STABLE_HI = 2'd2;
    localparam logic [1:0] WAIT_LO   = 2'd3;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 32'hFF_FFFF || LONG_CYCLES < 1) begin : g_bad_cfg
        $error("btn_debounce_in: parameter out of range");
    end

    logic [N_BTN-1:0] meta, sync;

    always_ff @(posedge clk_100_i or negedge rst_n_i)
        if (!rst_n_i) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= btn_i;
            sync <= meta;
        end

    genvar k;
    for (k = 0; k < N_BTN; k++) begin : g_ch
        logic [1:0]       state, state_nx;
        logic [DB_W-1:0]  cnt, cnt_nx;
        logic [CNT_W-1:0] pcnt;
        logic             done, rise, fall, press, rel;

        assign done = cnt == DB_MAX;
        assign rise = state == WAIT_HI && sync[k] && done;
        assign fall = state == WAIT_LO && !sync[k] && done;

        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            case (state)
                STABLE_LO:
                    if (sync[k]) begin
                        state_nx = WAIT_HI;
                        cnt_nx   = DB_W'(1);
                    end
                WAIT_HI:
                    if (!sync[k]) begin
                        state_nx = STABLE_LO;
                        cnt_nx   = '0;
                    end else if (done) begin
                        state_nx = STABLE_HI;
                        cnt_nx   = '0;
                    end else
                        cnt_nx = cnt + 1'b1;
                STABLE_HI:
                    if (!sync[k]) begin
                        state_nx = WAIT_LO;
                        cnt_nx   = DB_W'(1);
                    end
                WAIT_LO:
                    if (sync[k]) begin
                        state_nx = STABLE_HI;
                        cnt_nx   = '0;
                    end else if (done) begin
                        state_nx = STABLE_LO;
                        cnt_nx   = '0;
                    end else
                        cnt_nx = cnt + 1'b1;
            endcase
        end

        // The counter follows the registered pulse, so a clear sampled during the pulse cycle overrides it.
        always_ff @(posedge clk_100_i or negedge rst_n_i)
            if (!rst_n_i) begin
                state <= STABLE_LO;
                cnt   <= '0;
                press <= 1'b0;
                rel   <= 1'b0;
                pcnt  <= '0;
            end else begin
                state <= state_nx;
                cnt   <= cnt_nx;
                press <= rise;
                rel   <= fall;
                pcnt  <= clr_cnt_i ? '0 : pcnt + CNT_W'(press);
            end

        // STABLE_HI and WAIT_LO are exactly the states where the accepted level is high.
        assign btn_level_o[k]                 = state[1];
        assign btn_press_o[k]                 = press;
        assign btn_release_o[k]               = rel;
        assign press_cnt_o[k*CNT_W +: CNT_W]  = pcnt;

`ifdef BTN_LONG_PRESS_EN
        localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
        localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
        logic [HOLD_W-1:0] hold;
        logic              long_p;

        // Hold time freezes at HOLD_MAX so a single press yields a single pulse; a release edge suppresses it.
        always_ff @(posedge clk_100_i or negedge rst_n_i)
            if (!rst_n_i) begin
                hold   <= '0;
                long_p <= 1'b0;
            end else begin
                hold   <= (rise || fall) ? '0 : (state[1] && hold != HOLD_MAX) ? hold + 1'b1 : hold;
                long_p <= !fall && state[1] && hold == HOLD_MAX - 1'b1;
            end

        assign btn_long_o[k] = long_p;
`else
        assign btn_long_o[k] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_btn_debounce_in.sv
// tb_btn_debounce_in: directed vector table plus hand sequences for latency, bounce, wrap/clear, simultaneity, reset and long press.
module tb_btn_debounce_in;
    localparam int N_BTN = 4, DB = 4, CNT_W = 4, LONG = 20;

    logic        clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
    logic [3:0]  btn = '0;
    logic [3:0]  btn_level, btn_press, btn_release, btn_long;
    logic [15:0] press_cnt;
    int          n_cmp = 0, n_bad = 0;
    int          cyc, pulses, lat;
    bit          found;

    always #5 clk = ~clk;

    btn_debounce_in #(
        .N_BTN(N_BTN), .DEBOUNCE_CYCLES(DB), .CNT_W(CNT_W), .LONG_CYCLES(LONG)
    ) dut (
        .clk_100_i(clk), .rst_n_i(rst_n), .btn_i(btn), .clr_cnt_i(clr),
        .btn_level_o(btn_level), .btn_press_o(btn_press), .btn_release_o(btn_release),
        .press_cnt_o(press_cnt), .btn_long_o(btn_long)
    );

    typedef struct {
        logic [3:0]  btn;
        logic        clr;
        int          hold;
        logic [3:0]  level;
        logic [15:0] cnt;
    } vec_t;
    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ev(input bit rel, input int ch, output int n, output bit seen);
        n = 0;
        do begin
            tick();
            n++;
            seen = rel ? btn_release[ch] : btn_press[ch];
        end while (!seen && n < 40);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn   = '0;
        clr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    always @(negedge clk)
        if (rst_n) begin
            if ((btn_press & btn_release) != 4'b0) chk("press_release_overlap", 32'(btn_press & btn_release), 0);
`ifndef BTN_LONG_PRESS_EN
            if (btn_long != 4'b0) chk("long_tied_low", 32'(btn_long), 0);
`endif
        end

    initial begin
        vecs[0] = '{4'b0001, 1'b0, 12, 4'b0001, 16'h0001};
        vecs[1] = '{4'b0011, 1'b0, 12, 4'b0011, 16'h0011};
        vecs[2] = '{4'b0010, 1'b0, 12, 4'b0010, 16'h0011};
        vecs[3] = '{4'b1010, 1'b0, 12, 4'b1010, 16'h1011};
        vecs[4] = '{4'b0000, 1'b0, 12, 4'b0000, 16'h1011};
        vecs[5] = '{4'b0000, 1'b1,  2, 4'b0000, 16'h0000};
        vecs[6] = '{4'b0101, 1'b0, 12, 4'b0101, 16'h0101};
        vecs[7] = '{4'b0000, 1'b0, 12, 4'b0000, 16'h0101};

        tick();
        tick();
        chk("reset_outputs", {btn_level, btn_press, btn_release, btn_long, press_cnt}, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            btn = vecs[i].btn;
            clr = vecs[i].clr;
            repeat (vecs[i].hold) tick();
            clr = 1'b0;
            chk($sformatf("vec%0d_level", i), 32'(btn_level), 32'(vecs[i].level));
            chk($sformatf("vec%0d_cnt", i), 32'(press_cnt), 32'(vecs[i].cnt));
        end

        // clean press on ch0
        do_reset();
        btn = 4'b0001;
        wait_ev(1'b0, 0, cyc, found);
        chk("press_latency", cyc - 1, 6);
        chk("press_level_same_cycle", 32'(btn_level[0]), 1);
        tick();
        chk("press_one_cycle", 32'(btn_press[0]), 0);
        repeat (17) tick();
        chk("press_cnt_ch0", 32'(press_cnt[3:0]), 1);

        // bounce on ch1
        do_reset();
        pulses = 0;
        for (int i = 0; i < 28; i++) begin
            btn[1] = (i < 8) && (i % 4 < 2);
            tick();
            pulses += int'(btn_press[1]);
        end
        chk("bounce_press_pulses", pulses, 0);
        chk("bounce_level", 32'(btn_level[1]), 0);
        chk("bounce_cnt", 32'(press_cnt[7:4]), 0);

        // wrap and clear on ch2
        do_reset();
        for (int p = 1; p <= 16; p++) begin
            btn[2] = 1'b1;
            repeat (10) tick();
            btn[2] = 1'b0;
            repeat (10) tick();
            if (p == 15) chk("cnt_at_15", 32'(press_cnt[11:8]), 15);
        end
        chk("cnt_wrap", 32'(press_cnt[11:8]), 0);
        btn[2] = 1'b1;
        wait_ev(1'b0, 2, cyc, found);
        chk("clr_press_pulse_seen", 32'(found), 1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_wins", 32'(press_cnt[11:8]), 0);
        tick();
        chk("clr_holds", 32'(press_cnt[11:8]), 0);

        // simultaneous channels
        do_reset();
        btn = 4'hF;
        wait_ev(1'b0, 0, cyc, found);
        chk("simul_press", 32'(btn_press), 32'hF);
        chk("simul_level_hi", 32'(btn_level), 32'hF);
        repeat (3) tick();
        btn = 4'h0;
        wait_ev(1'b1, 0, cyc, found);
        chk("simul_release", 32'(btn_release), 32'hF);
        chk("simul_level_lo", 32'(btn_level), 0);
        tick();
        chk("simul_cnt", 32'(press_cnt), 32'h1111);

        // reset mid-wait on ch3
        do_reset();
        btn = 4'b1000;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("midwait_reset_async", {btn_level, btn_press, btn_release, btn_long, press_cnt}, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("midwait_reset_hold%0d", i), {btn_level, btn_press, btn_release, btn_long, press_cnt}, 0);
        end
        rst_n = 1'b1;
        wait_ev(1'b0, 3, cyc, found);
        chk("midwait_press_latency", cyc - 1, 6);
        tick();
        chk("midwait_cnt", 32'(press_cnt), 32'h1000);

`ifdef BTN_LONG_PRESS_EN
        do_reset();
        btn = 4'b0001;
        wait_ev(1'b0, 0, cyc, found);
        pulses = 0;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (btn_long[0]) begin
                pulses++;
                lat = i;
            end
        end
        chk("long_pulse_count", pulses, 1);
        chk("long_latency", lat, 20);
        btn = 4'b0000;
        wait_ev(1'b1, 0, cyc, found);
        repeat (5) tick();
        btn = 4'b0001;
        wait_ev(1'b0, 0, cyc, found);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 10) btn = 4'b0000;
            tick();
            pulses += int'(btn_long[0]);
        end
        chk("long_none_short_hold", pulses, 0);
`else
        do_reset();
        btn = 4'b1111;
        repeat (40) tick();
        chk("long_disabled_zero", 32'(btn_long), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
